// File: rtl/sample_packet_buffer.sv
// sample_packet_buffer: ping-pong ADC packet buffer feeding the FX3 GPIF read state machine
module sample_packet_buffer #(
  parameter int ADC_WIDTH = 10,
  parameter int PACKET_WORDS = 8192,
  parameter int ADDR_WIDTH = 13
) (
  input  logic inclk,
  input  logic nReset,
  input  logic [ADC_WIDTH-1:0] adcData,
  input  logic adcValid,
  input  logic fx3isReading,
  input  logic clearFlags,
  output logic [15:0] dataOut,
  output logic dataReady,
  output logic bufferOverflow,
  output logic bufferUnderrun
);
  typedef enum logic [1:0] {RD_WAIT, RD_STREAM, RD_HOLD} rdState_t;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(PACKET_WORDS - 1);
  logic [15:0] mem [0:2**(ADDR_WIDTH+1)-1];
  rdState_t state;
  logic wrBank, rdBank, fx3Prev, delivered;
  logic [ADDR_WIDTH-1:0] wrIdx, rdIdx;
  logic [1:0] bankFull, fullNext;
  logic startEv, underrunEv, bankRelease, wrEn, wrLast, overflowEv;
  always_comb begin
    startEv = state == RD_WAIT && fx3isReading && !fx3Prev;
    underrunEv = startEv && !bankFull[rdBank];
    bankRelease = state != RD_WAIT && !fx3isReading && delivered;
    wrEn = adcValid && (!bankFull[wrBank] || (bankRelease && rdBank == wrBank));
    overflowEv = adcValid && !wrEn;
    wrLast = wrEn && wrIdx == LAST_IDX;
    fullNext = bankFull;
    if (bankRelease) fullNext[rdBank] = 1'b0;
    if (wrLast) fullNext[wrBank] = 1'b1;
  end
  always_ff @(posedge inclk)
    if (wrEn) mem[{wrBank, wrIdx}] <= 16'(adcData);
  // rdIdx is always 0 while waiting, so the start cycle already addresses word 0
  always_ff @(posedge inclk or negedge nReset)
    if (!nReset) begin
      state <= RD_WAIT;
      wrBank <= 1'b0;
      rdBank <= 1'b0;
      wrIdx <= '0;
      rdIdx <= '0;
      bankFull <= '0;
      fx3Prev <= 1'b0;
      delivered <= 1'b0;
      dataOut <= '0;
      dataReady <= 1'b0;
      bufferOverflow <= 1'b0;
      bufferUnderrun <= 1'b0;
    end else begin
      fx3Prev <= fx3isReading;
      bankFull <= fullNext;
      dataReady <= bankFull[rdBank] && state == RD_WAIT;
      bufferOverflow <= overflowEv || (bufferOverflow && !clearFlags);
      bufferUnderrun <= underrunEv || (bufferUnderrun && !clearFlags);
      if (wrEn) begin
        wrIdx <= wrIdx + 1'b1;
        if (wrLast) wrBank <= !wrBank;
      end
      case (state)
        RD_WAIT: if (startEv) begin
          delivered <= 1'b0;
          if (bankFull[rdBank]) begin
            dataOut <= mem[{rdBank, rdIdx}];
            rdIdx <= rdIdx + 1'b1;
            state <= RD_STREAM;
          end else begin
            dataOut <= '0;
            state <= RD_HOLD;
          end
        end
        default: if (!fx3isReading) begin
          rdBank <= rdBank ^ delivered;
          rdIdx <= '0;
          delivered <= 1'b0;
          state <= RD_WAIT;
        end else if (state == RD_STREAM) begin
          dataOut <= mem[{rdBank, rdIdx}];
          rdIdx <= rdIdx + 1'b1;
          if (rdIdx == LAST_IDX) begin
            delivered <= 1'b1;
            state <= RD_HOLD;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_sample_packet_buffer.sv
// tb_sample_packet_buffer: directed checks of fill, stream, abort, overflow, underrun and reset
module tb_sample_packet_buffer;
  logic inclk = 1'b0, nReset = 1'b0, adcValid = 1'b0, fx3isReading = 1'b0, clearFlags = 1'b0;
  logic [9:0] adcData = '0;
  logic [15:0] dataOut;
  logic dataReady, bufferOverflow, bufferUnderrun;
  int tests = 0, fails = 0;
  sample_packet_buffer dut (
    .inclk(inclk),
    .nReset(nReset),
    .adcData(adcData),
    .adcValid(adcValid),
    .fx3isReading(fx3isReading),
    .clearFlags(clearFlags),
    .dataOut(dataOut),
    .dataReady(dataReady),
    .bufferOverflow(bufferOverflow),
    .bufferUnderrun(bufferUnderrun)
  );
  always #5 inclk = ~inclk;
  task automatic tick();
    @(posedge inclk);
    #1;
  endtask
  task automatic check(string tag, int obs, int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic feed(int count, int start);
    for (int n = 0; n < count; n++) begin
      adcValid = 1'b1;
      adcData = 10'((start + n) % 1024);
      tick();
    end
    adcValid = 1'b0;
  endtask
  // raises fx3isReading and counts words that differ from k mod 1024
  task automatic stream(string tag, int words);
    int errs = 0;
    fx3isReading = 1'b1;
    for (int k = 0; k < words; k++) begin
      tick();
      if (dataOut != 16'(k % 1024)) errs++;
    end
    check(tag, errs, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge inclk);
    #1;
    check("rst dataOut", dataOut, 0);
    check("rst dataReady", dataReady, 0);
    check("rst overflow", bufferOverflow, 0);
    check("rst underrun", bufferUnderrun, 0);
    nReset = 1'b1;
    tick();
    fx3isReading = 1'b1;
    tick();
    check("underrun flag", bufferUnderrun, 1);
    check("underrun dataOut", dataOut, 0);
    check("underrun banks", dut.bankFull, 0);
    fx3isReading = 1'b0;
    tick();
    check("underrun rdBank", dut.rdBank, 0);
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;
    check("underrun clear", bufferUnderrun, 0);
    feed(8192, 0);
    check("fill ready lag", dataReady, 0);
    tick();
    check("fill ready", dataReady, 1);
    check("fill banks", dut.bankFull, 1);
    check("fill wrBank", dut.wrBank, 1);
    stream("abort words", 100);
    fx3isReading = 1'b0;
    tick();
    tick();
    check("abort ready", dataReady, 1);
    check("abort banks", dut.bankFull, 1);
    stream("full words", 8192);
    tick();
    check("hold dataOut", dataOut, 1023);
    fx3isReading = 1'b0;
    tick();
    check("release banks", dut.bankFull, 0);
    check("release rdBank", dut.rdBank, 1);
    tick();
    check("release ready", dataReady, 0);
    feed(16384, 0);
    check("both full banks", dut.bankFull, 3);
    check("both full no ovf", bufferOverflow, 0);
    feed(1, 0);
    check("overflow flag", bufferOverflow, 1);
    check("overflow wrIdx", dut.wrIdx, 0);
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;
    check("overflow clear", bufferOverflow, 0);
    check("overflow ready", dataReady, 1);
    stream("bank1 words", 8192);
    fx3isReading = 1'b0;
    adcValid = 1'b1;
    adcData = 10'h155;
    tick();
    adcValid = 1'b0;
    check("race no ovf", bufferOverflow, 0);
    check("race wrIdx", dut.wrIdx, 1);
    check("race banks", dut.bankFull, 1);
    check("race rdBank", dut.rdBank, 0);
    tick();
    stream("prereset words", 4000);
    check("prereset dataOut", dataOut, 3999 % 1024);
    nReset = 1'b0;
    #1;
    check("async rst dataOut", dataOut, 0);
    check("async rst ready", dataReady, 0);
    check("async rst banks", dut.bankFull, 0);
    fx3isReading = 1'b0;
    tick();
    nReset = 1'b1;
    feed(8191, 0);
    tick();
    tick();
    check("refill not ready", dataReady, 0);
    feed(1, 8191);
    tick();
    check("refill ready", dataReady, 1);
    stream("refill words", 8192);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sample_packet_buffer.md
Name: sample_packet_buffer

Overview:
- Ping-pong packet buffer upstream of the FX3 GPIF read state machine.
- Collects ADC samples into two banks of PACKET_WORDS 16-bit words each.
- Raises dataReady, which drives the state machine's readData input, when a full bank is ready.
- Streams that bank onto the GPIF data bus while fx3isReading is high; flags overflow and underrun.

Parameters:
ADC_WIDTH, 10, sample width; samples are zero-extended to 16 bits.
PACKET_WORDS, 8192, words per bank and per FX3 packet.
ADDR_WIDTH, 13, index width; requires 2^ADDR_WIDTH == PACKET_WORDS.

Ports:
inclk  in  1  system clock; all logic on its rising edge.
nReset  in  1  asynchronous, active-low reset.
adcData  in  ADC_WIDTH  sample, qualified by adcValid.
adcValid  in  1  one-cycle strobe per sample.
fx3isReading  in  1  high while the GPIF state machine is in its send-packet state.
clearFlags  in  1  synchronous clear of the sticky flags.
dataOut  out  16  word to the GPIF data bus.
dataReady  out  1  the bank at the read pointer is full; connects to readData.
bufferOverflow  out  1  sticky; a sample was dropped.
bufferUnderrun  out  1  sticky; a read started with no full bank.

Behaviour:
- Reset (async, nReset low): wrBank=0, rdBank=0, wrIdx=0, rdIdx=0, bankFull[1:0]=0, dataOut=0, dataReady=0, bufferOverflow=0, bufferUnderrun=0. Reset mid-packet discards all buffered data.
- Storage: 2 x PACKET_WORDS x 16 block RAM, addressed {bank, index}. Registered read port.
- Write side:
  - On adcValid with bankFull[wrBank]=0: write {zeros, adcData} at {wrBank, wrIdx}; wrIdx++.
  - When wrIdx == PACKET_WORDS-1 is written: set bankFull[wrBank]; toggle wrBank; wrIdx wraps to 0.
  - On adcValid with bankFull[wrBank]=1: sample dropped; bufferOverflow<=1; wrIdx unchanged. Writing resumes at index 0 once that bank is released.
- Read FSM states: RD_WAIT, RD_STREAM, RD_HOLD.
  - RD_WAIT: on rising edge of fx3isReading (registered previous value low, current high):
    - bankFull[rdBank]=1: go to RD_STREAM with rdIdx=0.
    - bankFull[rdBank]=0: go to RD_HOLD; bufferUnderrun<=1; dataOut driven 0.
  - RD_STREAM, each cycle with fx3isReading high:
    - Read {rdBank, rdIdx}; rdIdx++.
    - dataOut presents word n in the cycle after index n is addressed, i.e. 1-cycle latency.
    - The first word appears the cycle after the rising edge.
    - After index PACKET_WORDS-1 is issued, go to RD_HOLD with the delivered flag set.
  - RD_HOLD: dataOut holds its last value.
  - On fx3isReading falling, from RD_STREAM or RD_HOLD:
    - All PACKET_WORDS words delivered: clear bankFull[rdBank], toggle rdBank.
    - Otherwise (early abort or underrun): bank retained, rdIdx<=0, and the same packet is resent in full next time.
    - Return to RD_WAIT.
- dataReady = bankFull[rdBank] && state==RD_WAIT; registered, so it updates 1 cycle after the underlying change. It is low during streaming.
- Simultaneous events:
  - A bank release and a write filling the other bank in the same cycle are both applied.
  - If the writer's next bank is released in the same cycle it would overflow, the release wins: no overflow, and the sample is written.
- clearFlags: clears both sticky flags. A flag-setting event in the same cycle wins.
- Index counters are ADDR_WIDTH bits with natural wrap; no arithmetic saturation elsewhere.

Test Plan:
- Feed 8192 samples (adcData=n mod 1024), fx3isReading low -> dataReady=1 within 2 cycles of the last sample; bankFull=01; wrBank=1.
- Then hold fx3isReading high 8193 cycles -> dataOut sequence 0,1,...,1023,0,... for 8192 words starting the cycle after the rising edge; on the fall, bank 0 released and dataReady=0 until bank 1 is full.
- Continuous adcValid every cycle with no reads -> after 16384 samples both banks full; sample 16385 sets bufferOverflow=1; clearFlags then clears it.
- fx3isReading rises with no full bank -> bufferUnderrun=1; dataOut=0; no bank state change.
- Drop fx3isReading after 100 words -> bank retained; the next read resends from word 0 with the identical full 8192-word sequence.
- Assert nReset mid-stream at word 4000 -> all outputs 0 immediately; after release, the first 8192 new samples are required before dataReady=1.
